// File: rtl/mask_match_sequencer_pkg.sv
// Shared definitions for the mask match sequencer: geometry, FSM encoding and
// the rank helper used to turn a bit position into a compressed-stream index.
package mask_match_sequencer_pkg;

  localparam int BITMASK_LENGTH = 16;
  localparam int INDEX_BITWIDTH = 5;
  localparam int MAX_NUM_OUTPUT = 2;
  localparam int COUNT_BITWIDTH = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Number of set bits strictly below pos, i.e. the rank of element pos in the compressed stream.
  function automatic logic [INDEX_BITWIDTH-1:0] popcount_below(
    input logic [BITMASK_LENGTH-1:0] mask,
    input logic [INDEX_BITWIDTH-1:0] pos
  );
    logic [INDEX_BITWIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < BITMASK_LENGTH; i++) begin
      if (i < int'(pos)) begin
        cnt = cnt + {{(INDEX_BITWIDTH-1){1'b0}}, mask[i]};
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mask_match_sequencer_picker.sv
// Combinational picker: finds the next few matched positions at or above the
// scan cursor and reports their W/A ranks, how many were found and where to resume.
module mask_pair_picker
  import mask_match_sequencer_pkg::*;
(
  input  logic [BITMASK_LENGTH-1:0]                i_mutual,
  input  logic [BITMASK_LENGTH-1:0]                i_maskW,
  input  logic [BITMASK_LENGTH-1:0]                i_maskA,
  input  logic [INDEX_BITWIDTH-1:0]                i_startIndex,
  output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] o_rankW,
  output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] o_rankA,
  output logic [COUNT_BITWIDTH-1:0]                o_count,
  output logic [INDEX_BITWIDTH-1:0]                o_nextStartIndex,
  output logic                                     o_lastFlag
);

  logic w_found;
  int   w_sel;
  int   w_cursor;

  // Each slot takes the lowest remaining match above the cursor, then the cursor moves past it.
  always_comb begin
    o_rankW          = '0;
    o_rankA          = '0;
    o_count          = '0;
    o_nextStartIndex = i_startIndex;
    w_cursor         = int'(i_startIndex);
    w_found          = 1'b0;
    w_sel            = 0;
    for (int k = 0; k < MAX_NUM_OUTPUT; k++) begin
      w_found = 1'b0;
      w_sel   = 0;
      for (int p = 0; p < BITMASK_LENGTH; p++) begin
        if (!w_found && (p >= w_cursor) && i_mutual[p]) begin
          w_found = 1'b1;
          w_sel   = p;
        end
      end
      if (w_found) begin
        o_rankW[k*INDEX_BITWIDTH +: INDEX_BITWIDTH] = popcount_below(i_maskW, INDEX_BITWIDTH'(w_sel));
        o_rankA[k*INDEX_BITWIDTH +: INDEX_BITWIDTH] = popcount_below(i_maskA, INDEX_BITWIDTH'(w_sel));
        o_count          = o_count + 1'b1;
        w_cursor         = w_sel + 1;
        o_nextStartIndex = INDEX_BITWIDTH'(w_sel + 1);
      end
    end
    o_lastFlag = ((i_mutual >> o_nextStartIndex) == '0);
  end

endmodule

// File: rtl/mask_match_sequencer.sv
// Sequential cluster sparsity matcher: latches a W/A mask pair, then emits the
// matched positions as compressed-stream ranks over one or more output beats.
module mask_match_sequencer
  import mask_match_sequencer_pkg::*;
(
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic                                     i_valid,
  output logic                                     o_ready,
  input  logic [BITMASK_LENGTH-1:0]                i_bitmaskW,
  input  logic [BITMASK_LENGTH-1:0]                i_bitmaskA,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] o_matchIdxW,
  output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] o_matchIdxA,
  output logic [COUNT_BITWIDTH-1:0]                o_matchCount,
  output logic                                     o_matchLast
);

  state_t r_state;
  state_t w_nextState;

  logic [BITMASK_LENGTH-1:0] r_maskW;
  logic [BITMASK_LENGTH-1:0] r_maskA;
  logic [BITMASK_LENGTH-1:0] r_mutual;
  logic [INDEX_BITWIDTH-1:0] r_startIndex;

  logic                                     w_transfer;
  logic                                     w_load;
  logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] w_rankW;
  logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] w_rankA;
  logic [COUNT_BITWIDTH-1:0]                w_count;
  logic [INDEX_BITWIDTH-1:0]                w_nextStartIndex;
  logic                                     w_lastFlag;

  assign o_ready    = (r_state == IDLE);
  assign w_transfer = i_valid && o_ready;
  // A beat is produced whenever the output register is empty or being drained this cycle.
  assign w_load     = (r_state == SCAN) && (!o_valid || i_ready);

  mask_pair_picker u_picker (
    .i_mutual         (r_mutual),
    .i_maskW          (r_maskW),
    .i_maskA          (r_maskA),
    .i_startIndex     (r_startIndex),
    .o_rankW          (w_rankW),
    .o_rankA          (w_rankA),
    .o_count          (w_count),
    .o_nextStartIndex (w_nextStartIndex),
    .o_lastFlag       (w_lastFlag)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_transfer) w_nextState = SCAN;
      SCAN:    if (w_load && w_lastFlag) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_maskW      <= '0;
      r_maskA      <= '0;
      r_mutual     <= '0;
      r_startIndex <= '0;
    end else if (w_transfer) begin
      r_maskW      <= i_bitmaskW;
      r_maskA      <= i_bitmaskA;
      r_mutual     <= i_bitmaskW & i_bitmaskA;
      r_startIndex <= '0;
    end else if (w_load) begin
      r_startIndex <= w_nextStartIndex;
    end
  end

  // Output register holds its contents while a beat is stalled; ovalid drops only when drained with nothing new.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_matchIdxW  <= '0;
      o_matchIdxA  <= '0;
      o_matchCount <= '0;
      o_matchLast  <= 1'b0;
    end else if (w_load) begin
      o_valid      <= 1'b1;
      o_matchIdxW  <= w_rankW;
      o_matchIdxA  <= w_rankA;
      o_matchCount <= w_count;
      o_matchLast  <= w_lastFlag;
    end else if (i_ready) begin
      o_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mask_match_sequencer.sv
// Directed self-checking bench for mask_match_sequencer with hand-computed beats.
module tb_mask_match_sequencer;

  logic        clock;
  logic        reset;
  logic        ivalid;
  logic        oready;
  logic [15:0] bitmaskW;
  logic [15:0] bitmaskA;
  logic        ovalid;
  logic        iready;
  logic [9:0]  matchIdxW;
  logic [9:0]  matchIdxA;
  logic [1:0]  matchCount;
  logic        matchLast;

  int checkCount = 0;
  int passCount  = 0;

  mask_match_sequencer dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_valid      (ivalid),
    .o_ready      (oready),
    .i_bitmaskW   (bitmaskW),
    .i_bitmaskA   (bitmaskA),
    .o_valid      (ovalid),
    .i_ready      (iready),
    .o_matchIdxW  (matchIdxW),
    .o_matchIdxA  (matchIdxA),
    .o_matchCount (matchCount),
    .o_matchLast  (matchLast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one mask pair and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic [15:0] w, input logic [15:0] a);
    int n;
    n = 0;
    while (!oready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("readyWait", {31'd0, oready}, 32'd1);
    ivalid   = 1'b1;
    bitmaskW = w;
    bitmaskA = a;
    tick();
    ivalid   = 1'b0;
    bitmaskW = '0;
    bitmaskA = '0;
  endtask

  // Wait for a valid beat, then compare every output field of it.
  task automatic expectBeat(input string tag, input logic [9:0] idxW, input logic [9:0] idxA,
                            input logic [1:0] cnt, input logic last);
    int n;
    n = 0;
    while (!ovalid && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, ".valid"}, {31'd0, ovalid}, 32'd1);
    checkOutput({tag, ".idxW"}, {22'd0, matchIdxW}, {22'd0, idxW});
    checkOutput({tag, ".idxA"}, {22'd0, matchIdxA}, {22'd0, idxA});
    checkOutput({tag, ".count"}, {30'd0, matchCount}, {30'd0, cnt});
    checkOutput({tag, ".last"}, {31'd0, matchLast}, {31'd0, last});
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".ovalid"}, {31'd0, ovalid}, 32'd0);
    checkOutput({tag, ".oready"}, {31'd0, oready}, 32'd1);
    checkOutput({tag, ".idxW"}, {22'd0, matchIdxW}, 32'd0);
    checkOutput({tag, ".idxA"}, {22'd0, matchIdxA}, 32'd0);
    checkOutput({tag, ".count"}, {30'd0, matchCount}, 32'd0);
    checkOutput({tag, ".last"}, {31'd0, matchLast}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ivalid   = 1'b0;
    iready   = 1'b1;
    bitmaskW = '0;
    bitmaskA = '0;
    tick();
    tick();
    checkIdleOutputs("reset");
    reset = 1'b0;
    tick();

    // Case 1: four matches over two beats, plus first-beat latency.
    applyStimulus(16'h00FF, 16'h0F0F);
    checkOutput("c1.latency", {31'd0, ovalid}, 32'd0);
    tick();
    expectBeat("c1.b1", {5'd1, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b0);
    tick();
    expectBeat("c1.b2", {5'd3, 5'd2}, {5'd3, 5'd2}, 2'd2, 1'b1);
    checkOutput("c1.readyDuringLast", {31'd0, oready}, 32'd1);
    tick();
    checkOutput("c1.drained", {31'd0, ovalid}, 32'd0);

    // Case 2: matches at both ends of the mask.
    applyStimulus(16'h8001, 16'h8001);
    expectBeat("c2", {5'd1, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b1);
    tick();
    checkOutput("c2.drained", {31'd0, ovalid}, 32'd0);

    // Case 3: empty mutual mask still produces one closing beat.
    applyStimulus(16'h00F0, 16'h000F);
    expectBeat("c3", 10'd0, 10'd0, 2'd0, 1'b1);
    tick();
    checkOutput("c3.oready", {31'd0, oready}, 32'd1);
    checkOutput("c3.drained", {31'd0, ovalid}, 32'd0);

    // Case 4: partial final beat leaves upper slot zero.
    applyStimulus(16'hFFFF, 16'h0015);
    expectBeat("c4.b1", {5'd2, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b0);
    tick();
    expectBeat("c4.b2", {5'd0, 5'd4}, {5'd0, 5'd2}, 2'd1, 1'b1);
    tick();

    // Case 5: backpressure freezes beat1 for three cycles.
    iready = 1'b0;
    applyStimulus(16'h00FF, 16'h0F0F);
    expectBeat("c5.b1", {5'd1, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectBeat("c5.hold", {5'd1, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b0);
    end
    iready = 1'b1;
    tick();
    expectBeat("c5.b2", {5'd3, 5'd2}, {5'd3, 5'd2}, 2'd2, 1'b1);
    tick();
    checkOutput("c5.noThirdBeat", {31'd0, ovalid}, 32'd0);
    tick();
    checkOutput("c5.stillIdle", {31'd0, ovalid}, 32'd0);

    // Case 6: reset mid-scan drops the cluster; next cluster runs cleanly.
    applyStimulus(16'h00FF, 16'h0F0F);
    tick();
    checkOutput("c6.preReset", {31'd0, ovalid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkIdleOutputs("c6.reset");
    applyStimulus(16'h8001, 16'h8001);
    expectBeat("c6.c2", {5'd1, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b1);
    tick();
    checkOutput("c6.drained", {31'd0, ovalid}, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
